// File: rtl/mux_pipe_sel_if.sv
// Bus bundle for mux_pipe_sel: channel bank, select/force controls and the registered result.
// in_valid_i qualifies the sample presented this cycle; hold_i=1 freezes every pipeline register and
// drops that cycle's sample; out_valid_o marks out_o/sel_err_o as carrying a valid sample. There is no ready.
interface mux_pipe_sel_if #(
    parameter int NUM_IN = 8,
    parameter int DATA_W = 1
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    logic [NUM_IN*DATA_W-1:0] in_data_i;
    logic [SEL_W-1:0]         sel_i;
    logic                     force_i;
    logic                     in_valid_i;
    logic                     hold_i;
    logic [DATA_W-1:0]        out_o;
    logic                     out_valid_o;
    logic                     sel_err_o;

    modport master (
        output in_data_i, sel_i, force_i, in_valid_i, hold_i,
        input  out_o, out_valid_o, sel_err_o
    );

    modport slave (
        input  in_data_i, sel_i, force_i, in_valid_i, hold_i,
        output out_o, out_valid_o, sel_err_o
    );
endinterface

// File: rtl/mux_pipe_sel.sv
// Pipelined, registered N:1 selector with force override, valid qualifier, stall and out-of-range flag.
// The whole sample function is resolved before stage 0; later stages only delay {value, err, valid}.
module mux_pipe_sel #(
    parameter int                NUM_IN    = 8,
    parameter int                DATA_W    = 1,
    parameter int                STAGES    = 1,
    parameter logic [DATA_W-1:0] FORCE_VAL = '1
) (
    input logic           clk,
    input logic           rst,
    mux_pipe_sel_if.slave bus
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    logic [DATA_W-1:0] sel_data;
    logic              sel_hit;
    logic [DATA_W-1:0] value_d;
    logic              err_d;

    logic [DATA_W-1:0] value_q [STAGES];
    logic [STAGES-1:0] err_q;
    logic [STAGES-1:0] valid_q;

    // Decoding by equality covers non-power-of-two NUM_IN: an unmatched select is the error case.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel_i == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                sel_data = bus.in_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        value_d = '0;
        err_d   = 1'b0;
        if (bus.force_i) begin
            value_d = FORCE_VAL;
        end else if (sel_hit) begin
            value_d = sel_data;
        end else begin
            err_d = 1'b1;
        end
    end

    // Data is captured whatever in_valid_i says; only the valid bit follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                value_q[s] <= '0;
            end
            err_q   <= '0;
            valid_q <= '0;
        end else if (!bus.hold_i) begin
            value_q[0] <= value_d;
            err_q[0]   <= err_d;
            valid_q[0] <= bus.in_valid_i;
            for (int s = 1; s < STAGES; s++) begin
                value_q[s] <= value_q[s-1];
                err_q[s]   <= err_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign bus.out_o       = value_q[STAGES-1];
    assign bus.out_valid_o = valid_q[STAGES-1];
    assign bus.sel_err_o   = err_q[STAGES-1];
endmodule
